regfile_seq: RTL and testbench
==============================

# regfile_seq

Multi-cycle control sequencer for the tiny16 16-entry register file. It fetches instruction words over a request/acknowledge memory port, latches them into an internal instruction register, and drives the register file's select, write-enable and PC/SP step strobes. It also drives the memory address source and the register-file input mux. It sits between the memory interface and the register file and is the only block that writes register-file control lines.

## Interface
Parameters:
- `SP_ADDR_EN_DEFAULT`, 1: when 1, the address mux selects SP during stack memory phases; when 0, stack phases still sequence, but the address mux selects PC (test/bring-up only).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_rdata` in 16: memory read data; it is both the instruction word and the POP data.
- `mem_ack` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write request (PUSH), valid with `mem_req`.
- `addr_sel` out 1: 0 = address from PC, 1 = address from SP.
- `src_sel` out 4, `dst_sel` out 4: register-file read and write selects.
- `in_en`, `up_en`, `lo_en` out 1: register-file full, upper-byte and lower-byte write enables.
- `in_sel` out 2: register-file input mux. 0 = src register, 1 = {8'h00, imm8}, 2 = `mem_rdata`.
- `pc_inc`, `sp_inc`, `sp_dec` out 1: single-cycle step strobes.
- `halted` out 1: the HALT instruction has executed.

## Operation
- Instruction format: [15:12] opcode, [11:8] dst, [7:4] src, [7:0] imm8. The src and imm8 fields overlap.
- Register indices: PC=1, SP=2, BA=3, RA=4. The register file ignores writes to index 0.
- Opcodes:
  - 0x0 NOP.
  - 0x1 MOV: dst ← src.
  - 0x2 LDL: dst[7:0] ← imm8.
  - 0x3 LDU: dst[15:8] ← imm8.
  - 0x4 PUSH src.
  - 0x5 POP dst.
  - 0x6 CALL: RA ← PC, then PC ← BA.
  - 0xF HALT.
  - All other opcodes execute as NOP.
- States: FETCH, EXEC, CALL2, PUSH_MEM, POP_MEM, HALT.
- FETCH:
  - Drive `mem_req`=1, `addr_sel`=0.
  - On `mem_ack`: latch IR ← `mem_rdata`, pulse `pc_inc`, go to EXEC.
- EXEC, one cycle per opcode; each returns to FETCH unless noted:
  - MOV: `in_sel`=0, `in_en`.
  - LDL: `in_sel`=1, `lo_en`.
  - LDU: `in_sel`=1, `up_en`.
  - CALL: `src_sel`=PC, `dst_sel`=RA, `in_sel`=0, `in_en`; go to CALL2.
  - PUSH: pulse `sp_dec`; go to PUSH_MEM.
  - POP: go to POP_MEM.
  - HALT: go to HALT.
- CALL2: `src_sel`=BA, `dst_sel`=PC, `in_sel`=0, `in_en`; go to FETCH.
- PUSH_MEM:
  - Drive `mem_req`, `mem_we`, `addr_sel`=1, `src_sel`=src. The register-file `out` port supplies the write data.
  - Hold until `mem_ack`, then go to FETCH.
- POP_MEM:
  - Drive `mem_req`, `addr_sel`=1.
  - On `mem_ack`: `in_sel`=2, `in_en`, `dst_sel`=dst, and pulse `sp_inc` in the same cycle; then go to FETCH.
  - POP with dst=SP leaves SP+1, because the register file gives the step strobe priority. This is defined behaviour, not an error.
- HALT: all strobes 0, `halted`=1. Only reset exits this state.
- Outside the cycles listed above, `src_sel`/`dst_sel` follow the IR fields and every enable/strobe is 0.

## Timing
- Reset (asynchronous assert, synchronous release): state=FETCH, IR=0, every output 0 except `mem_req`. `mem_req` is 1 in the first cycle after release.
- Latency in cycles, zero-wait memory (`mem_ack` same cycle as request):
  - NOP, MOV, LDL, LDU: 2.
  - CALL: 3.
  - PUSH, POP: 3.
- Wait states extend FETCH, PUSH_MEM and POP_MEM by exactly the number of cycles `mem_ack` is low.
- `mem_req`, `mem_we` and `addr_sel` remain stable while waiting.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset asserted mid-request drops `mem_req` immediately; any outstanding access is abandoned.
- At most one strobe among `pc_inc`/`sp_inc`/`sp_dec` is active per cycle.
- All outputs are registered-state decodes: Moore, except that `pc_inc` and the POP write depend on `mem_ack`.

## Configuration
- `TINY16_STACK_EN`:
  - Defined: PUSH, POP and CALL execute as described above.
  - Undefined: opcodes 0x4–0x6 execute as NOP; states PUSH_MEM, POP_MEM and CALL2 are not compiled; `sp_inc`, `sp_dec` and `addr_sel` are tied to 0.

## Structure
- Package `tiny16_pkg`, shared with the register file and the future ALU:
  - opcode constants;
  - register index constants PC/SP/BA/RA;
  - `in_sel` encodings;
  - state enum typedef.
- One sub-module, `regfile_seq_decode`: combinational IR → opcode class and field extraction. The FSM remains in `regfile_seq`.

## Test plan
- Reset, zero-wait memory, fetch 0x2312 (LDL r3,0x12): FETCH pulses `pc_inc`; next cycle `lo_en`=1, `dst_sel`=3, `in_sel`=1; then back to FETCH.
- Fetch with `mem_ack` delayed 3 cycles: `mem_req`=1 for 4 cycles with `addr_sel`=0; `pc_inc` pulses exactly once, in the ack cycle.
- PUSH r5 (0x4050): EXEC pulses `sp_dec`; PUSH_MEM drives `mem_we`=1, `addr_sel`=1, `src_sel`=5; `mem_req` holds until ack.
- POP r6 (0x5600) with ack on the 2nd cycle: ack cycle shows `in_en`=1, `in_sel`=2, `dst_sel`=6, `sp_inc`=1.
- CALL (0x6000): cycle 1 `dst_sel`=4, `src_sel`=1, `in_en`; cycle 2 `dst_sel`=1, `src_sel`=3, `in_en`. Repeat with `TINY16_STACK_EN` undefined: no writes occur.
- HALT (0xF000), then `rst_n` pulsed low mid-cycle: `halted`=1 and all strobes 0 until reset; asynchronous clear observed before the next edge; fetch resumes after release.

Source files
------------

// File: rtl/tiny16_pkg.sv
// rtl/tiny16_pkg.sv - shared tiny16 constants: opcodes, register indices, in_sel codes, sequencer states
// Purpose: single source of encodings used by the register file, the control
//          sequencer and the future ALU.
// Ports:   none (package).
package tiny16_pkg;

  // Opcode field [15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDL  = 4'h2;
  localparam logic [3:0] OP_LDU  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_POP  = 4'h5;
  localparam logic [3:0] OP_CALL = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register-file indices with fixed roles
  localparam logic [3:0] REG_PC = 4'd1;
  localparam logic [3:0] REG_SP = 4'd2;
  localparam logic [3:0] REG_BA = 4'd3;
  localparam logic [3:0] REG_RA = 4'd4;

  // Register-file input mux encodings
  localparam logic [1:0] IN_SEL_SRC = 2'd0;
  localparam logic [1:0] IN_SEL_IMM = 2'd1;
  localparam logic [1:0] IN_SEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_CALL2    = 3'd2,
    ST_PUSH_MEM = 3'd3,
    ST_POP_MEM  = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_MOV  = 3'd1,
    CLS_LDL  = 3'd2,
    CLS_LDU  = 3'd3,
    CLS_PUSH = 3'd4,
    CLS_POP  = 3'd5,
    CLS_CALL = 3'd6,
    CLS_HALT = 3'd7
  } op_class_e;

endpackage

// File: rtl/regfile_seq_decode.sv
// rtl/regfile_seq_decode.sv - combinational instruction-register decode for regfile_seq
// Purpose: map the latched instruction word to an opcode class and extract the
//          dst/src register fields. With TINY16_STACK_EN undefined, PUSH, POP
//          and CALL decode as NOP.
// Ports:   ir_i       - latched instruction word
//          op_class_o - opcode class
//          dst_o      - IR[11:8] destination register index
//          src_o      - IR[7:4] source register index
module regfile_seq_decode
  import tiny16_pkg::*;
(
  input  logic [15:0] ir_i,
  output op_class_e   op_class_o,
  output logic [3:0]  dst_o,
  output logic [3:0]  src_o
);

  // Low nibble of imm8 is consumed by the register file, not by the sequencer.
  logic unused_imm_lo;
  assign unused_imm_lo = ^ir_i[3:0];

  assign dst_o = ir_i[11:8];
  assign src_o = ir_i[7:4];

  always_comb begin
    op_class_o = CLS_NOP;
    case (ir_i[15:12])
      OP_MOV:  op_class_o = CLS_MOV;
      OP_LDL:  op_class_o = CLS_LDL;
      OP_LDU:  op_class_o = CLS_LDU;
`ifdef TINY16_STACK_EN
      OP_PUSH: op_class_o = CLS_PUSH;
      OP_POP:  op_class_o = CLS_POP;
      OP_CALL: op_class_o = CLS_CALL;
`endif
      OP_HALT: op_class_o = CLS_HALT;
      default: op_class_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - tiny16 multi-cycle register-file control sequencer
// Purpose: fetch instructions over a req/ack memory port, latch them into IR
//          and drive every register-file control line. Stack operations
//          (PUSH/POP/CALL) are compiled only when TINY16_STACK_EN is defined.
// Ports:   clk, rst_n          - clock, asynchronous active-low reset
//          mem_rdata, mem_ack  - memory read data (instruction / POP data), completion
//          mem_req, mem_we     - memory request and write qualifier
//          addr_sel            - 0 = PC, 1 = SP address source
//          src_sel, dst_sel    - register-file read / write selects
//          in_en, up_en, lo_en - full / upper-byte / lower-byte write enables
//          in_sel              - register-file input mux select
//          pc_inc, sp_inc, sp_dec - single-cycle step strobes
//          halted              - HALT has executed
module regfile_seq
  import tiny16_pkg::*;
#(
  parameter int SP_ADDR_EN_DEFAULT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [3:0]  src_sel,
  output logic [3:0]  dst_sel,
  output logic        in_en,
  output logic        up_en,
  output logic        lo_en,
  output logic [1:0]  in_sel,
  output logic        pc_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        halted
);

  localparam logic SP_ADDR_EN = (SP_ADDR_EN_DEFAULT != 0);

  seq_state_e  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  op_class_e   op_class;
  logic [3:0]  ir_dst, ir_src;
  logic        stack_phase;

  regfile_seq_decode u_decode (
    .ir_i       (ir_q),
    .op_class_o (op_class),
    .dst_o      (ir_dst),
    .src_o      (ir_src)
  );

  // Next state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_class)
`ifdef TINY16_STACK_EN
          CLS_CALL: state_d = ST_CALL2;
          CLS_PUSH: state_d = ST_PUSH_MEM;
          CLS_POP:  state_d = ST_POP_MEM;
`endif
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_FETCH;
        endcase
      end
`ifdef TINY16_STACK_EN
      ST_CALL2:    state_d = ST_FETCH;
      ST_PUSH_MEM: if (mem_ack) state_d = ST_FETCH;
      ST_POP_MEM:  if (mem_ack) state_d = ST_FETCH;
`endif
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode. Everything is gated by rst_n so that an asserted reset
  // drops mem_req (and ignores a stray mem_ack) before the next clock edge.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    stack_phase = 1'b0;
    src_sel     = ir_src;
    dst_sel     = ir_dst;
    in_en       = 1'b0;
    up_en       = 1'b0;
    lo_en       = 1'b0;
    in_sel      = IN_SEL_SRC;
    pc_inc      = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          pc_inc  = mem_ack;
        end
        ST_EXEC: begin
          case (op_class)
            CLS_MOV: in_en = 1'b1;
            CLS_LDL: begin
              in_sel = IN_SEL_IMM;
              lo_en  = 1'b1;
            end
            CLS_LDU: begin
              in_sel = IN_SEL_IMM;
              up_en  = 1'b1;
            end
`ifdef TINY16_STACK_EN
            CLS_CALL: begin
              src_sel = REG_PC;
              dst_sel = REG_RA;
              in_en   = 1'b1;
            end
            CLS_PUSH: sp_dec = 1'b1;
`endif
            default: ;
          endcase
        end
`ifdef TINY16_STACK_EN
        ST_CALL2: begin
          src_sel = REG_BA;
          dst_sel = REG_PC;
          in_en   = 1'b1;
        end
        ST_PUSH_MEM: begin
          mem_req     = 1'b1;
          mem_we      = 1'b1;
          stack_phase = 1'b1;
        end
        ST_POP_MEM: begin
          mem_req     = 1'b1;
          stack_phase = 1'b1;
          // POP data is written in the ack cycle, together with the SP step.
          if (mem_ack) begin
            in_sel = IN_SEL_MEM;
            in_en  = 1'b1;
            sp_inc = 1'b1;
          end
        end
`endif
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Stack phases always sequence; only the address source honours the parameter.
  assign addr_sel = stack_phase & SP_ADDR_EN;

endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - self-checking bench for regfile_seq against an instruction-level model
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_sel;
  logic [3:0]  src_sel, dst_sel;
  logic        in_en, up_en, lo_en;
  logic [1:0]  in_sel;
  logic        pc_inc, sp_inc, sp_dec, halted;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TINY16_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif
  localparam bit AS = 1'b1;

  // Model of the IR fields visible on src_sel/dst_sel between instructions
  logic [3:0] ps, pd;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .src_sel(src_sel), .dst_sel(dst_sel),
    .in_en(in_en), .up_en(up_en), .lo_en(lo_en), .in_sel(in_sel),
    .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec), .halted(halted)
  );

  wire [19:0] obs = {mem_req, mem_we, addr_sel, src_sel, dst_sel,
                     in_en, up_en, lo_en, in_sel, pc_inc, sp_inc, sp_dec, halted};

  function automatic logic [19:0] v(input logic req, we, as, input logic [3:0] s, d,
                                    input logic ien, uen, len, input logic [1:0] isel,
                                    input logic pci, spi, spd, h);
    return {req, we, as, s, d, ien, uen, len, isel, pci, spi, spd, h};
  endfunction

  task automatic check(input string tag, input logic [19:0] e);
    n_checks++;
    assert (obs === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, e);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, check, move to next falling edge.
  task automatic cyc(input logic ack, input logic [15:0] rd, input logic [19:0] e, input string tag);
    mem_ack   = ack;
    mem_rdata = rd;
    #1;
    check(tag, e);
    @(negedge clk);
  endtask

  // Fetch and execute one instruction with wf fetch wait states and wm stack-access wait states.
  task automatic run_instr(input logic [15:0] word, input int wf, input int wm);
    logic [3:0] op, d, s;
    logic [19:0] e;
    op = word[15:12];
    d  = word[11:8];
    s  = word[7:4];
    for (int i = 0; i < wf; i++)
      cyc(1'b0, 16'($urandom), v(1,0,0,ps,pd,0,0,0,0,0,0,0,0), "fetch_wait");
    cyc(1'b1, word, v(1,0,0,ps,pd,0,0,0,0,1,0,0,0), "fetch_ack");
    ps = s;
    pd = d;
    e = v(0,0,0,s,d,0,0,0,0,0,0,0,0);
    case (op)
      4'h1: e = v(0,0,0,s,d,1,0,0,0,0,0,0,0);
      4'h2: e = v(0,0,0,s,d,0,0,1,1,0,0,0,0);
      4'h3: e = v(0,0,0,s,d,0,1,0,1,0,0,0,0);
      4'h4: if (STACK) e = v(0,0,0,s,d,0,0,0,0,0,0,1,0);
      4'h6: if (STACK) e = v(0,0,0,4'd1,4'd4,1,0,0,0,0,0,0,0);
      default: ;
    endcase
    // A stray mem_ack here must be ignored: no request is outstanding.
    cyc(1'($urandom_range(0, 1)), 16'($urandom), e, "exec");
    if (STACK && op == 4'h6)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), v(0,0,0,4'd3,4'd1,1,0,0,0,0,0,0,0), "call2");
    if (STACK && op == 4'h4) begin
      for (int i = 0; i < wm; i++)
        cyc(1'b0, 16'($urandom), v(1,1,AS,s,d,0,0,0,0,0,0,0,0), "push_wait");
      cyc(1'b1, 16'($urandom), v(1,1,AS,s,d,0,0,0,0,0,0,0,0), "push_ack");
    end
    if (STACK && op == 4'h5) begin
      for (int i = 0; i < wm; i++)
        cyc(1'b0, 16'($urandom), v(1,0,AS,s,d,0,0,0,0,0,0,0,0), "pop_wait");
      cyc(1'b1, 16'($urandom), v(1,0,AS,s,d,1,0,0,2,0,1,0,0), "pop_ack");
    end
  endtask

  initial begin
    logic [15:0] w;
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    ps = 4'h0;
    pd = 4'h0;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("reset_state", 20'h00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_instr(16'h2312, 0, 0);
    run_instr(16'h1230, 3, 0);
    run_instr(16'h4050, 0, 2);
    run_instr(16'h5600, 0, 1);
    run_instr(16'h6000, 0, 0);
    run_instr(16'h5200, 0, 0);
    run_instr(16'h3A5C, 1, 0);
    run_instr(16'h7123, 0, 0);
    run_instr(16'h0000, 2, 0);

    // Randomized instruction stream (HALT excluded)
    for (int k = 0; k < 200; k++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a fetch is outstanding drops mem_req before the next edge
    mem_ack = 1'b0;
    #1;
    check("prereset_wait", v(1,0,0,ps,pd,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("reset_mid_req", 20'h00000);
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    ps = 4'h0;
    pd = 4'h0;
    run_instr(16'h2345, 0, 0);

    // HALT holds until reset
    run_instr(16'hF000, 1, 0);
    for (int i = 0; i < 5; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), v(0,0,0,0,0,0,0,0,0,0,0,0,1), "halted");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_async_clear", 20'h00000);
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    ps = 4'h0;
    pd = 4'h0;
    run_instr(16'h1450, 0, 0);
    run_instr(16'h4070, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
